divider_arbiter: RTL and testbench

Shares one `pipelined_divider` instance among `num_requesters` independent clients. Each cycle it round-robin arbitrates between pending requests and issues at most one division into the divider. It carries the requester ID through a tag pipeline matched to the divider latency, and routes each quotient/remainder back to the client that issued it. It sits between the Sobel stages that need division (normalisation, gradient scaling) and the single shared divider.

---
 rtl/divider_arbiter.sv | 149 ++++++++++++++
 tb/tb_divider_arbiter.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/divider_arbiter.sv
// divider_arbiter: round-robin sharing of one pipelined divider among
// several clients, with ID tags tracking every in-flight operation.
module divider_arbiter #(
    parameter int num_requesters = 4,
    parameter int dividend_width = 12,
    parameter int divisor_width  = 6,
    parameter int div_latency    = dividend_width + 1
) (
    input  logic                                     clock,
    input  logic                                     reset,
    input  logic [num_requesters-1:0]                req_valid,
    input  logic [num_requesters*dividend_width-1:0] req_dividend,
    input  logic [num_requesters*divisor_width-1:0]  req_divisor,
    output logic [num_requesters-1:0]                req_ready,
    output logic                                     div_in_valid,
    output logic [dividend_width-1:0]                div_dividend,
    output logic [divisor_width-1:0]                 div_divisor,
    input  logic                                     div_out_valid,
    input  logic [dividend_width-1:0]                div_quotient,
    input  logic [dividend_width-1:0]                div_remainder,
    output logic [num_requesters-1:0]                res_valid,
    output logic [dividend_width-1:0]                res_quotient,
    output logic [dividend_width-1:0]                res_remainder,
    output logic                                     res_dbz,
    output logic                                     protocol_error
);

    localparam int id_width = (num_requesters > 1) ? $clog2(num_requesters) : 1;

    typedef struct packed {
        logic                valid;
        logic [id_width-1:0] id;
        logic                dbz;
    } tag_t;

    logic [id_width-1:0]       rr_ptr;
    logic [id_width-1:0]       win_id;
    logic [id_width-1:0]       next_ptr;
    logic [num_requesters-1:0] grant;
    logic                      found;
    logic                      handshake;
    logic [dividend_width-1:0] win_dividend;
    logic [divisor_width-1:0]  win_divisor;
    logic [id_width-1:0]       issue_id;
    logic                      issue_dbz;
    tag_t                      tags [div_latency];
    tag_t                      tail;
    logic [num_requesters-1:0] tail_hot;
    int                        idx;

    // First pending request at or after rr_ptr, wrapping around.
    always_comb begin
        grant  = '0;
        win_id = '0;
        found  = 1'b0;
        idx    = 0;
        for (int k = 0; k < num_requesters; k++) begin
            idx = (int'(rr_ptr) + k) % num_requesters;
            if (!found && req_valid[idx]) begin
                grant[idx] = 1'b1;
                win_id     = idx[id_width-1:0];
                found      = 1'b1;
            end
        end
        if (reset) begin
            grant = '0;
            found = 1'b0;
        end
    end

    assign req_ready = grant;
    assign handshake = found;

    assign win_dividend = req_dividend[int'(win_id)*dividend_width +: dividend_width];
    assign win_divisor  = req_divisor[int'(win_id)*divisor_width +: divisor_width];

    always_comb begin
        next_ptr = win_id + id_width'(1);
        if (int'(win_id) == num_requesters - 1) begin
            next_ptr = '0;
        end
    end

    assign tail = tags[div_latency-1];

    always_comb begin
        tail_hot = '0;
        for (int i = 0; i < num_requesters; i++) begin
            tail_hot[i] = (int'(tail.id) == i);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rr_ptr       <= '0;
            div_in_valid <= 1'b0;
            div_dividend <= '0;
            div_divisor  <= '0;
            issue_id     <= '0;
            issue_dbz    <= 1'b0;
        end else begin
            div_in_valid <= handshake;
            if (handshake) begin
                rr_ptr       <= next_ptr;
                div_dividend <= win_dividend;
                div_divisor  <= win_divisor;
                issue_id     <= win_id;
                issue_dbz    <= (win_divisor == '0);
            end
        end
    end

    // Tag stage 0 follows the issue register, so the tail lines up
    // with div_out_valid exactly div_latency cycles after issue.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int j = 0; j < div_latency; j++) begin
                tags[j] <= '0;
            end
        end else begin
            tags[0] <= '{valid: div_in_valid, id: issue_id, dbz: issue_dbz};
            for (int j = 1; j < div_latency; j++) begin
                tags[j] <= tags[j-1];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            res_valid      <= '0;
            res_quotient   <= '0;
            res_remainder  <= '0;
            res_dbz        <= 1'b0;
            protocol_error <= 1'b0;
        end else begin
            res_valid <= '0;
            if (tail.valid && div_out_valid) begin
                res_valid     <= tail_hot;
                res_quotient  <= div_quotient;
                res_remainder <= div_remainder;
                res_dbz       <= tail.dbz;
            end
            if (tail.valid != div_out_valid) begin
                protocol_error <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_divider_arbiter.sv
// Directed bench for divider_arbiter with a behavioural
// truncating divider model of fixed latency.
module tb_divider_arbiter;

    localparam int N  = 4;
    localparam int DW = 12;
    localparam int SW = 6;
    localparam int L  = DW + 1;

    logic            clock;
    logic            reset;
    logic [N-1:0]    req_valid;
    logic [N*DW-1:0] req_dividend;
    logic [N*SW-1:0] req_divisor;
    logic [N-1:0]    req_ready;
    logic            div_in_valid;
    logic [DW-1:0]   div_dividend;
    logic [SW-1:0]   div_divisor;
    logic            div_out_valid;
    logic [DW-1:0]   div_quotient;
    logic [DW-1:0]   div_remainder;
    logic [N-1:0]    res_valid;
    logic [DW-1:0]   res_quotient;
    logic [DW-1:0]   res_remainder;
    logic            res_dbz;
    logic            protocol_error;

    int total = 0;
    int bad   = 0;
    logic early = 1'b0;

    logic          mv [L];
    logic [23:0]   md [L];

    divider_arbiter dut (
        .clock(clock),
        .reset(reset),
        .req_valid(req_valid),
        .req_dividend(req_dividend),
        .req_divisor(req_divisor),
        .req_ready(req_ready),
        .div_in_valid(div_in_valid),
        .div_dividend(div_dividend),
        .div_divisor(div_divisor),
        .div_out_valid(div_out_valid),
        .div_quotient(div_quotient),
        .div_remainder(div_remainder),
        .res_valid(res_valid),
        .res_quotient(res_quotient),
        .res_remainder(res_remainder),
        .res_dbz(res_dbz),
        .protocol_error(protocol_error)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Divide-by-zero gives all-ones quotient and the dividend as remainder.
    function automatic logic [23:0] divmod(input logic [DW-1:0] a, input logic [SW-1:0] b);
        int x;
        int y;
        int q;
        int r;
        x = int'($signed(a));
        y = int'(b);
        if (y == 0) begin
            return {12'hFFF, a};
        end
        q = x / y;
        r = x % y;
        return {q[11:0], r[11:0]};
    endfunction

    always @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < L; i++) mv[i] <= 1'b0;
        end else begin
            mv[0] <= div_in_valid;
            md[0] <= divmod(div_dividend, div_divisor);
            for (int i = 1; i < L; i++) begin
                mv[i] <= mv[i-1];
                md[i] <= md[i-1];
            end
        end
    end

    assign div_out_valid = early ? mv[L-2] : mv[L-1];
    assign div_quotient  = early ? md[L-2][23:12] : md[L-1][23:12];
    assign div_remainder = early ? md[L-2][11:0] : md[L-1][11:0];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req_valid = '0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic set_req(input int i, input int a, input int b);
        req_dividend[i*DW +: DW] = a[DW-1:0];
        req_divisor[i*SW +: SW]  = b[SW-1:0];
        req_valid[i] = 1'b1;
    endtask

    logic [11:0] sq [4] = '{12'h021, 12'hFF4, 12'h007, 12'h020};
    logic [11:0] sr [4] = '{12'h001, 12'hFFE, 12'h007, 12'h01F};
    logic [11:0] bq [3] = '{12'd10, 12'd9, 12'd9};
    logic [11:0] br [3] = '{12'd0, 12'd9, 12'd8};

    initial begin
        reset = 1'b1;
        req_valid = '0;
        req_dividend = '0;
        req_divisor = '0;

        do_reset();
        check("rst_div_in_valid", div_in_valid, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_perr", protocol_error, 0);
        check("rst_dbz", res_dbz, 0);
        check("rst_dividend", div_dividend, 0);
        check("rst_divisor", div_divisor, 0);
        check("rst_quot", res_quotient, 0);
        check("rst_rem", res_remainder, 0);

        // single request
        set_req(2, -100, 7);
        #1 check("single_ready", req_ready, 4'b0100);
        tick();
        req_valid = '0;
        check("single_issue", div_in_valid, 1);
        check("single_dvd", div_dividend, 12'hF9C);
        check("single_dvs", div_divisor, 7);
        repeat (13) tick();
        check("single_early", res_valid, 0);
        check("single_perr", protocol_error, 0);
        tick();
        check("single_valid", res_valid, 4'b0100);
        check("single_quot", res_quotient, 12'hFF2);
        check("single_rem", res_remainder, 12'hFFE);
        check("single_dbz", res_dbz, 0);
        tick();
        check("single_strobe", res_valid, 0);

        // all four clients at once
        do_reset();
        set_req(0, 100, 3);
        set_req(1, -50, 4);
        set_req(2, 63, 8);
        set_req(3, 2047, 63);
        for (int c = 0; c < 4; c++) begin
            #1 check("multi_ready", req_ready, 32'(1 << c));
            tick();
        end
        req_valid = '0;
        repeat (11) tick();
        for (int c = 0; c < 4; c++) begin
            check("multi_valid", res_valid, 32'(1 << c));
            check("multi_quot", res_quotient, sq[c]);
            check("multi_rem", res_remainder, sr[c]);
            tick();
        end
        check("multi_done", res_valid, 0);

        // back-to-back from client 1
        do_reset();
        for (int k = 0; k < 3; k++) begin
            set_req(1, 100 - k, 10);
            #1 check("b2b_ready", req_ready, 4'b0010);
            tick();
        end
        req_valid = '0;
        repeat (12) tick();
        for (int k = 0; k < 3; k++) begin
            check("b2b_valid", res_valid, 4'b0010);
            check("b2b_quot", res_quotient, bq[k]);
            check("b2b_rem", res_remainder, br[k]);
            tick();
        end

        // zero divisor
        do_reset();
        set_req(0, 5, 0);
        tick();
        req_valid = '0;
        repeat (14) tick();
        check("dbz_valid", res_valid, 4'b0001);
        check("dbz_flag", res_dbz, 1);
        check("dbz_quot", res_quotient, 12'hFFF);
        check("dbz_rem", res_remainder, 12'h005);
        check("dbz_perr", protocol_error, 0);
        tick();
        check("dbz_strobe", res_valid, 0);
        check("dbz_hold", res_dbz, 1);

        // reset while operations are in flight
        do_reset();
        req_valid = 4'b0001;
        set_req(0, 40, 3);
        tick();
        req_valid = '0;
        set_req(1, 41, 3);
        tick();
        req_valid = '0;
        set_req(2, 42, 3);
        tick();
        req_valid = '0;
        tick();
        tick();
        reset = 1'b1;
        req_valid = 4'b1111;
        #1 check("mid_rst_ready", req_ready, 0);
        tick();
        reset = 1'b0;
        req_valid = '0;
        check("mid_rst_issue", div_in_valid, 0);
        for (int c = 6; c <= 30; c++) begin
            check("mid_rst_no_res", res_valid, 0);
            tick();
        end
        req_valid = 4'b1111;
        set_req(0, 77, 5);
        #1 check("mid_rst_ptr", req_ready, 4'b0001);
        tick();
        req_valid = '0;
        repeat (14) tick();
        check("mid_rst_valid", res_valid, 4'b0001);
        check("mid_rst_quot", res_quotient, 12'h00F);
        check("mid_rst_rem", res_remainder, 12'h002);
        check("mid_rst_perr", protocol_error, 0);

        // divider valid one cycle early
        do_reset();
        early = 1'b1;
        req_valid = '0;
        set_req(2, 30, 5);
        tick();
        req_valid = '0;
        repeat (12) tick();
        check("mm_before", protocol_error, 0);
        tick();
        check("mm_set", protocol_error, 1);
        check("mm_no_res14", res_valid, 0);
        tick();
        check("mm_no_res15", res_valid, 0);
        repeat (5) tick();
        check("mm_sticky", protocol_error, 1);
        early = 1'b0;
        do_reset();
        check("mm_cleared", protocol_error, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
